mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side front end for the byte-entry SRAM macro: turns core load/store requests (byte/half/word, signed/unsigned) into SRAM cycles.
- Stores issue as one masked write and then drain through the SRAM's registered write path.
- Loads are assembled from sequential per-byte combinational reads, then zero- or sign-extended.
- Sits between the core's LSU pipeline stage and the data SRAM.

Parameters:
- ADDR_WIDTH, 13, SRAM address width; each entry holds one byte in bits [7:0].
- DATA_WIDTH, 32, request/response and SRAM data width.
- NUM_WMASKS, 4, byte lanes; mask bit k writes byte lane k to entry addr+k.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; transfer occurs when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH  byte address (any alignment)
- req_wdata  in  DATA_WIDTH  store data, low bytes first
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  load result; 0 for stores
- mem_csb  out  1  chip select, active low
- mem_web  out  1  write enable, active high
- mem_wmask  out  NUM_WMASKS  byte write mask
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_din  out  DATA_WIDTH  SRAM write data
- mem_dout  in  DATA_WIDTH  SRAM combinational read data; only [7:0] used

Behaviour:
- Reset (sync, active-high): state=IDLE, byte counter=0.
  - Outputs during and after reset: rsp_valid=0, rsp_rdata=0, mem_web=0, mem_wmask=0, mem_csb=1, mem_addr=0, mem_din=0.
  - req_ready=0 while rst=1.
- Ordering: one request outstanding at a time. req_ready=1 only in IDLE. req_valid outside IDLE is ignored. No response backpressure.
- States:
  - IDLE: on accept, latch we/size/unsigned/addr/wdata. Store goes to WRITE; load goes to READ with k=0.
  - WRITE (1 cycle): mem_csb=0, mem_web=1, mem_addr=base, mem_wmask per size (byte 0001, half 0011, word 1111), mem_din=wdata with unmasked lanes zeroed. Next state WDRAIN.
  - WDRAIN (1 cycle): mem_web=0, mem_wmask=0, mem_csb=0. The SRAM commits its registered write at the end of this cycle. Next state DONE.
  - READ: mem_csb=0, mem_web=0, mem_addr=(base+k) mod 2^ADDR_WIDTH.
    - Each edge captures mem_dout[7:0] into result byte k, then k++.
    - After the capture with k=nbytes-1 (nbytes 1/2/4), go to DONE.
  - DONE (1 cycle): rsp_valid=1. Next state IDLE.
    - Load rsp_rdata: assembled bytes; bits above 8*nbytes are zero-filled if req_unsigned, else copies of bit 8*nbytes-1. Word is unaffected.
    - Store rsp_rdata: 0.
- Latency, accept edge at end of cycle T:
  - store: rsp_valid in T+3; data readable from T+3.
  - load byte/half/word: rsp_valid in T+2 / T+3 / T+5.
  - Next accept possible in the cycle after DONE.
- Outside WRITE/WDRAIN/READ: mem_csb=1, mem_web=0, mem_wmask=0. mem_addr and mem_din hold their last value.
- Read-after-write: a load accepted after a store's DONE always observes the stored data, because of the WDRAIN bubble.
- Misalignment: no trap; each byte is an independent entry.
- Address wrap:
  - Load byte addresses wrap modulo 2^ADDR_WIDTH.
  - Store addresses wrap inside the SRAM via addr+k.
- Reset mid-operation: abandon; no rsp_valid. A store whose WRITE cycle was already presented may still commit in the SRAM; this is allowed. mem_web is 0 from the cycle after reset is sampled.
- rsp_rdata holds its value until the next DONE or reset.

Test Plan:
- Store word 0x11223344 at 0x0010, then load word 0x0010 unsigned → store rsp_valid at T+3. Entries 0x10..0x13 = 0x44,0x33,0x22,0x11. Load rsp_rdata=0x11223344 at T+5.
- Store byte 0x80 at 0x0100; load byte signed → 0xFFFFFF80; load byte unsigned → 0x00000080; each rsp at T+2.
- Store half 0xBEEF at 0x1FFF; load half signed 0x1FFF → entry 0x1FFF=0xEF, entry 0x0000=0xBE; rsp_rdata=0xFFFFBEEF. Load addresses wrap.
- Store word 0xAAAA5555 at 0x20, then immediately (next accept) load word 0x20 → 0xAAAA5555, no stale data. req_ready=0 throughout the store and load.
- Hold req_valid=1 during a load word → only one request accepted; req_ready=0 for 4 READ cycles plus DONE. Second accept occurs in the cycle after DONE.
- Assert rst in the 2nd READ cycle of a load word → no rsp_valid. All mem outputs return to their reset values. req_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// LSU-side front end for a byte-per-entry SRAM: one masked write per store,
// and loads built from sequential single-byte reads, then zero- or sign-extended.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [NUM_WMASKS-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int CNT_W = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_DONE
    } state_t;

    function automatic logic [NUM_WMASKS-1:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = NUM_WMASKS'(1);
            2'b01:   lane_mask = NUM_WMASKS'(3);
            default: lane_mask = '1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_expand(input logic [NUM_WMASKS-1:0] m);
        byte_expand = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            byte_expand[8*i +: 8] = {8{m[i]}};
        end
    endfunction

    function automatic logic [CNT_W-1:0] last_index(input logic [1:0] size);
        case (size)
            2'b00:   last_index = CNT_W'(0);
            2'b01:   last_index = CNT_W'(1);
            default: last_index = CNT_W'(NUM_WMASKS - 1);
        endcase
    endfunction

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              size_q;
    logic                    zext_q;
    logic [NUM_WMASKS-1:0]   wmask_q;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_din_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    accept;
    logic                    last_capture;
    logic [DATA_WIDTH-1:0]   assembled;
    logic [DATA_WIDTH-1:0]   extended;
    logic                    unused_dout_bits;

    // Each SRAM entry carries a single byte; the upper read lanes are don't-care.
    assign unused_dout_bits = ^mem_dout[DATA_WIDTH-1:8];

    assign accept       = req_valid && req_ready;
    assign last_capture = (state == S_READ) && (cnt == last_index(size_q));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: a default before the case keeps this block free of inferred latches.
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = req_we ? S_WRITE : S_READ;
            S_WRITE:  state_next = S_WDRAIN;
            S_WDRAIN: state_next = S_DONE;
            S_READ:   if (last_capture) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode; reset forces the idle bus so nothing leaks while rst is high.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_csb   = 1'b1;
        mem_web   = 1'b0;
        mem_wmask = '0;
        if (!rst) begin
            case (state)
                S_IDLE:   req_ready = 1'b1;
                S_WRITE: begin
                    mem_csb   = 1'b0;
                    mem_web   = 1'b1;
                    mem_wmask = wmask_q;
                end
                S_WDRAIN: mem_csb = 1'b0;
                S_READ:   mem_csb = 1'b0;
                S_DONE:   rsp_valid = 1'b1;
                default:  req_ready = 1'b0;
            endcase
        end
    end

    // Drop the byte on the bus into its slot, then extend from the top loaded byte.
    always_comb begin
        assembled = rdata_q;
        assembled[{cnt, 3'b000} +: 8] = mem_dout[7:0];
        case (size_q)
            2'b00:   extended = {{(DATA_WIDTH-8){~zext_q & assembled[7]}}, assembled[7:0]};
            2'b01:   extended = {{(DATA_WIDTH-16){~zext_q & assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    // Request latch, read walker and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_q      <= '0;
            zext_q      <= 1'b0;
            wmask_q     <= '0;
            cnt         <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                size_q     <= req_size;
                zext_q     <= req_unsigned;
                wmask_q    <= lane_mask(req_size);
                mem_addr_q <= req_addr;
                cnt        <= '0;
                if (req_we) begin
                    mem_din_q <= req_wdata & byte_expand(lane_mask(req_size));
                end
            end
            if (state == S_READ) begin
                rdata_q <= assembled;
                if (last_capture) begin
                    rsp_rdata_q <= extended;
                end else begin
                    cnt        <= cnt + 1'b1;
                    mem_addr_q <= mem_addr_q + 1'b1;
                end
            end
            if (state == S_WDRAIN) begin
                rsp_rdata_q <= '0;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-entry SRAM model with a registered write path,
// plus a golden byte array from which load results and latencies are predicted.
module tb_mem_access_unit;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int NW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_csb;
    logic          mem_web;
    logic [NW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    logic [7:0]    sram [DEPTH];
    logic [7:0]    gold [DEPTH];
    logic [23:0]   junk;
    logic          init_req;
    logic          wr_pend = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_din;
    logic [NW-1:0] wr_mask;

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // SRAM: combinational read, write captured on one edge and committed on the next.
    assign mem_dout = {junk, sram[mem_addr]};

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= gold[i];
        end
        if (wr_pend) begin
            for (int k = 0; k < NW; k++) begin
                if (wr_mask[k]) sram[wr_addr + AW'(k)] <= wr_din[8*k +: 8];
            end
        end
        wr_pend <= !mem_csb && mem_web;
        wr_addr <= mem_addr;
        wr_din  <= mem_din;
        wr_mask <= mem_wmask;
    end

    always @(posedge clk) if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [DW-1:0] exp_load(input logic [AW-1:0] a, input logic [1:0] s,
                                               input logic uns);
        logic [DW-1:0] v;
        int n;
        n = nbytes(s);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = gold[a + AW'(k)];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [NW-1:0] exp_mask(input logic [1:0] s);
        logic [NW-1:0] m;
        m = '0;
        for (int k = 0; k < nbytes(s); k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] exp_din(input logic [1:0] s, input logic [DW-1:0] w);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = w[8*k +: 8];
        return v;
    endfunction

    task automatic gold_store(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] w);
        for (int k = 0; k < nbytes(s); k++) gold[a + AW'(k)] = w[8*k +: 8];
    endtask

    // Drives one request and observes it; returns at the falling edge inside the response cycle.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output int lat, output logic [DW-1:0] rdata, output bit busy,
                         output logic [NW-1:0] seen_mask, output logic [DW-1:0] seen_din);
        int w;
        @(negedge clk);
        junk         = 24'($urandom);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = AW'($urandom);
        req_wdata    = $urandom;
        lat       = -1;
        busy      = 1'b0;
        rdata     = 'x;
        seen_mask = 'x;
        seen_din  = 'x;
        for (int n = 1; n <= 20; n++) begin
            if (we && n == 1) begin
                seen_mask = mem_wmask;
                seen_din  = mem_din;
            end
            if (req_ready) busy = 1'b1;
            if (rsp_valid) begin
                lat   = n;
                rdata = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 0", req_ready);
        end
        checks++;
        if ({rsp_valid, mem_csb, mem_web, mem_wmask} !== {1'b0, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/csb/web/wmask %b%b%b%b expected 0100000",
                     rsp_valid, mem_csb, mem_web, mem_wmask);
        end
        checks++;
        if ({mem_addr, mem_din, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr %h din %h rdata %h expected all zero",
                     mem_addr, mem_din, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word();
        int lat;
        bit busy;
        logic [DW-1:0] rd, din;
        logic [NW-1:0] msk;
        gold_store(13'h0010, 2'b10, 32'h1122_3344);
        issue(1'b1, 2'b10, 1'b0, 13'h0010, 32'h1122_3344, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 3 || rd !== 32'h0 || busy) begin
            errors++;
            $display("FAIL word_store_rsp: got lat %0d rdata %h busy %b expected lat 3 rdata 0 busy 0",
                     lat, rd, busy);
        end
        checks++;
        if (msk !== 4'b1111 || din !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word_store_bus: got mask %b din %h expected 1111 11223344", msk, din);
        end
        checks++;
        if ({sram[13'h13], sram[13'h12], sram[13'h11], sram[13'h10]} !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word_store_entries: got %h%h%h%h expected 11223344",
                     sram[13'h13], sram[13'h12], sram[13'h11], sram[13'h10]);
        end
        issue(1'b0, 2'b10, 1'b1, 13'h0010, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 5 || rd !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word_load: got lat %0d rdata %h expected lat 5 rdata 11223344", lat, rd);
        end
    endtask

    task automatic test_byte_sign();
        int lat;
        bit busy;
        logic [DW-1:0] rd, din;
        logic [NW-1:0] msk;
        gold_store(13'h0100, 2'b00, 32'h5A5A_5A80);
        issue(1'b1, 2'b00, 1'b0, 13'h0100, 32'h5A5A_5A80, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 3 || msk !== 4'b0001 || din !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_store: got lat %0d mask %b din %h expected 3 0001 00000080",
                     lat, msk, din);
        end
        issue(1'b0, 2'b00, 1'b0, 13'h0100, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 2 || rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL byte_load_signed: got lat %0d rdata %h expected 2 ffffff80", lat, rd);
        end
        issue(1'b0, 2'b00, 1'b1, 13'h0100, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 2 || rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_load_unsigned: got lat %0d rdata %h expected 2 00000080", lat, rd);
        end
    endtask

    task automatic test_half_wrap();
        int lat;
        bit busy;
        logic [DW-1:0] rd, din;
        logic [NW-1:0] msk;
        gold_store(13'h1FFF, 2'b01, 32'h1234_BEEF);
        issue(1'b1, 2'b01, 1'b0, 13'h1FFF, 32'h1234_BEEF, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 3 || msk !== 4'b0011 || din !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL half_store: got lat %0d mask %b din %h expected 3 0011 0000beef",
                     lat, msk, din);
        end
        checks++;
        if (sram[13'h1FFF] !== 8'hEF || sram[13'h0000] !== 8'hBE) begin
            errors++;
            $display("FAIL half_store_wrap: got 1fff=%h 0000=%h expected ef be",
                     sram[13'h1FFF], sram[13'h0000]);
        end
        issue(1'b0, 2'b01, 1'b0, 13'h1FFF, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 3 || rd !== 32'hFFFF_BEEF) begin
            errors++;
            $display("FAIL half_load_wrap: got lat %0d rdata %h expected 3 ffffbeef", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busy;
        logic [DW-1:0] rd, din;
        logic [NW-1:0] msk;
        gold_store(13'h0020, 2'b10, 32'hAAAA_5555);
        issue(1'b1, 2'b10, 1'b0, 13'h0020, 32'hAAAA_5555, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 3 || busy) begin
            errors++;
            $display("FAIL b2b_store: got lat %0d busy %b expected 3 0", lat, busy);
        end
        issue(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 5 || busy || rd !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL b2b_load: got lat %0d busy %b rdata %h expected 5 0 aaaa5555",
                     lat, busy, rd);
        end
    endtask

    task automatic test_hold_valid();
        int lat, a0;
        bit busy;
        logic [DW-1:0] e1, e2;
        e1 = exp_load(13'h0010, 2'b10, 1'b0);
        e2 = exp_load(13'h0100, 2'b00, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 13'h0010; req_wdata = $urandom;
        a0 = acc_cnt;
        @(negedge clk);
        lat = -1;
        busy = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (req_ready) busy = 1'b1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== 5 || busy || rsp_rdata !== e1 || acc_cnt !== a0 + 1) begin
            errors++;
            $display("FAIL hold_first: got lat %0d busy %b rdata %h accepts %0d expected 5 0 %h 1",
                     lat, busy, rsp_rdata, acc_cnt - a0, e1);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || acc_cnt !== a0 + 1) begin
            errors++;
            $display("FAIL hold_idle: got ready %b valid %b accepts %0d expected 1 0 1",
                     req_ready, rsp_valid, acc_cnt - a0);
        end
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 13'h0100;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (rsp_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== 2 || rsp_rdata !== e2 || acc_cnt !== a0 + 2) begin
            errors++;
            $display("FAIL hold_second: got lat %0d rdata %h accepts %0d expected 2 %h 2",
                     lat, rsp_rdata, acc_cnt - a0, e2);
        end
    endtask

    task automatic test_random();
        int lat;
        bit busy;
        logic [DW-1:0] rd, din, wd, e;
        logic [NW-1:0] msk;
        logic we, uns;
        logic [1:0] sz;
        logic [AW-1:0] a;
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom);
            uns = 1'($urandom);
            a   = 13'h1FF4 + AW'($urandom_range(0, 23));
            wd  = $urandom;
            if (we) begin
                gold_store(a, sz, wd);
                issue(1'b1, sz, uns, a, wd, lat, rd, busy, msk, din);
                checks++;
                if (lat !== 3 || rd !== 32'h0 || busy || msk !== exp_mask(sz) || din !== exp_din(sz, wd)) begin
                    errors++;
                    $display("FAIL rand_store %0d: got lat %0d rdata %h busy %b mask %b din %h expected 3 0 0 %b %h",
                             i, lat, rd, busy, msk, din, exp_mask(sz), exp_din(sz, wd));
                end
            end else begin
                e = exp_load(a, sz, uns);
                issue(1'b0, sz, uns, a, wd, lat, rd, busy, msk, din);
                checks++;
                if (lat !== nbytes(sz) + 1 || rd !== e || busy) begin
                    errors++;
                    $display("FAIL rand_load %0d: addr %h size %0d got lat %0d rdata %h busy %b expected %0d %h 0",
                             i, a, sz, lat, rd, busy, nbytes(sz) + 1, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit busy, seen;
        logic [DW-1:0] rd, din;
        logic [NW-1:0] msk;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b1;
        req_addr = 13'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during: got ready %b valid %b expected 0 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({mem_csb, mem_web, mem_wmask} !== {1'b1, 1'b0, 4'b0000} ||
            {mem_addr, mem_din, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got csb %b web %b mask %b addr %h din %h rdata %h expected reset values",
                     mem_csb, mem_web, mem_wmask, mem_addr, mem_din, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b expected 1", req_ready);
        end
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_no_rsp: got rsp_valid after abandoned load expected none");
        end
        issue(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0, lat, rd, busy, msk, din);
        checks++;
        if (lat !== 5 || rd !== exp_load(13'h0010, 2'b10, 1'b0)) begin
            errors++;
            $display("FAIL midrst_recover: got lat %0d rdata %h expected 5 %h",
                     lat, rd, exp_load(13'h0010, 2'b10, 1'b0));
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        junk = 24'($urandom);
        for (int i = 0; i < DEPTH; i++) gold[i] = 8'($urandom);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        test_reset();
        test_word();
        test_byte_sign();
        test_half_wrap();
        test_back_to_back();
        test_hold_valid();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
